// File: rtl/multirate_v4_div_29s_13s_seq.sv
// Sequential signed divider: restoring shift-subtract on magnitudes, sign fix-up at the end.
// Build option: define MULTIRATE_DIV_RADIX4_EN to retire two quotient bits per CALC cycle.

module multirate_v4_div_29s_13s_seq #(
  parameter int DIVIDEND_WIDTH = 29,
  parameter int DIVISOR_WIDTH  = 13
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIVIDEND_WIDTH-1:0] quotient,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int DW = DIVIDEND_WIDTH;
  localparam int VW = DIVISOR_WIDTH;
  localparam int RW = VW + 1;
`ifdef MULTIRATE_DIV_RADIX4_EN
  localparam int BPC = 2;
`else
  localparam int BPC = 1;
`endif
  localparam int N  = (DW + BPC - 1) / BPC;
  localparam int SW = N * BPC;
  localparam int CW = $clog2(N + 1);

  localparam logic [DW-1:0] Q_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] Q_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic [CW-1:0] cnt;
  logic [SW-1:0] qsh, qsh_nxt, q_work;
  logic [VW-1:0] prem, prem_nxt, r_work;
  logic [RW-1:0] trial;
  logic [VW-1:0] dvs, dvs_mag, dvd_lo;
  logic [DW-1:0] dvd_mag;
  logic          neg_dvd, neg_dvs, dvs_zero;
  logic [DW-1:0] q_mag, q_fix;
  logic [VW-1:0] r_fix;
  logic          ovf;

  assign accept  = in_ready & in_valid;
  assign dvd_mag = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
  assign dvs_mag = divisor[VW-1]  ? (~divisor  + VW'(1)) : divisor;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = CALC;
      CALC:    if (cnt == '0)  state_nxt = FIX;
      FIX:                     state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // NOTE: blocking assignments chain the cascaded stages within one cycle; state regs use <=.
  always_comb begin
    r_work = prem;
    q_work = qsh;
    trial  = '0;
    for (int i = 0; i < BPC; i++) begin
      trial  = {r_work, q_work[SW-1]};
      q_work = {q_work[SW-2:0], 1'b0};
      if (trial >= RW'(dvs)) begin
        r_work    = VW'(trial - RW'(dvs));
        q_work[0] = 1'b1;
      end else begin
        r_work = trial[VW-1:0];
      end
    end
    prem_nxt = r_work;
    qsh_nxt  = q_work;
  end

  // CALC holds N+1 cycles: N iterating cycles while cnt counts down, then one settle cycle at zero.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt      <= '0;
      qsh      <= '0;
      prem     <= '0;
      dvs      <= '0;
      dvd_lo   <= '0;
      neg_dvd  <= 1'b0;
      neg_dvs  <= 1'b0;
      dvs_zero <= 1'b0;
    end else if (accept) begin
      cnt      <= CW'(N);
      qsh      <= SW'(dvd_mag);
      prem     <= '0;
      dvs      <= dvs_mag;
      dvd_lo   <= dividend[VW-1:0];
      neg_dvd  <= dividend[DW-1];
      neg_dvs  <= divisor[VW-1];
      dvs_zero <= (divisor == '0);
    end else if (state == CALC && cnt != '0) begin
      cnt  <= cnt - CW'(1);
      qsh  <= qsh_nxt;
      prem <= prem_nxt;
    end
  end

  // Only -max-1 / -1 can produce a same-sign quotient magnitude of 2^(DW-1).
  assign q_mag = qsh[DW-1:0];
  assign ovf   = ~dvs_zero & ~(neg_dvd ^ neg_dvs) & q_mag[DW-1];

  always_comb begin
    q_fix = (neg_dvd ^ neg_dvs) ? (~q_mag + DW'(1)) : q_mag;
    r_fix = neg_dvd ? (~prem + VW'(1)) : prem;
    if (dvs_zero) begin
      q_fix = neg_dvd ? Q_MIN : Q_MAX;
      r_fix = dvd_lo;
    end else if (ovf) begin
      q_fix = Q_MAX;
      r_fix = '0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (state == FIX) begin
      quotient    <= q_fix;
      remainder   <= r_fix;
      div_by_zero <= dvs_zero;
      overflow    <= ovf;
    end
  end

endmodule
